// File: rtl/latency_memory_pkg.sv
// ============================================================================
// Module  : latency_memory_pkg
// Brief   : Shared FSM encoding and default geometry for the latency memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

package latency_memory_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Defaults shared with the cache and LSU so all agree on the memory shape.
  localparam int DEF_ADDR_W  = 7;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_LATENCY = 3;

endpackage

`default_nettype wire

// File: rtl/latency_memory_byte_merge.sv
// ============================================================================
// Module  : byte_merge
// Brief   : Combinational per-byte merge of a new word into an old word.
// Revision: 1.0
// ============================================================================
`default_nettype none

module byte_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);

  for (genvar gi = 0; gi < DATA_W/8; gi++) begin : g_byte
    assign merged[8*gi +: 8] = be[gi] ? new_word[8*gi +: 8] : old_word[8*gi +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/latency_memory.sv
// ============================================================================
// Module  : latency_memory
// Brief   : Single-port word memory with fixed access latency and byte-enable
//           stores behind valid/ready request and response channels.
// Revision: 1.0
// ============================================================================
`default_nettype none

module latency_memory
  import latency_memory_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                busy
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  // Contents are deliberately never reset; benches preload through this name.
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept;
  logic              w_complete;
  logic [DATA_W-1:0] w_old_word;
  logic [DATA_W-1:0] w_merged;

  assign w_old_word = mem[r_addr];

  byte_merge #(
    .DATA_W (DATA_W)
  ) u_byte_merge (
    .old_word (w_old_word),
    .new_word (r_wdata),
    .be       (r_be),
    .merged   (w_merged)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_complete  = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= CNT_W'(LATENCY - 1);
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_complete) begin
        r_rdata <= r_write ? w_merged : w_old_word;
      end
    end
  end

  // Reset gates the commit so an access aborted in WAIT never reaches memory.
  always_ff @(posedge clk) begin
    if (!reset && w_complete && r_write) begin
      mem[r_addr] <= w_merged;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign busy       = (r_state != S_IDLE);
  assign resp_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_latency_memory.sv
// ============================================================================
// Module  : tb_latency_memory
// Brief   : Self-checking bench for latency_memory (LATENCY=3 and LATENCY=1).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_latency_memory;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          failures = 0;

  // Main instance, LATENCY = 3
  logic        req_valid, req_ready, req_write, resp_valid, resp_ready, busy;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata, resp_rdata;
  logic [3:0]  req_be;

  // Second instance, LATENCY = 1
  logic        req_valid1, req_ready1, req_write1, resp_valid1, resp_ready1, busy1;
  logic [6:0]  req_addr1;
  logic [31:0] req_wdata1, resp_rdata1;
  logic [3:0]  req_be1;

  logic [31:0] model3 [0:127];
  logic [31:0] model1 [0:127];

  always #5 clk = ~clk;

  latency_memory #(.ADDR_W(7), .DATA_W(32), .LATENCY(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .busy(busy)
  );

  latency_memory #(.ADDR_W(7), .DATA_W(32), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_rdata(resp_rdata1),
    .busy(busy1)
  );

  function automatic logic [31:0] merge_ref(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  // One access on the LATENCY=3 instance, checked against the model.
  task automatic access(input logic wr, input logic [6:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input int hold, output logic [31:0] rd);
    logic [31:0] exp_d;
    int          lat;
    bit          ok;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_req_ready: got %b need 1", req_ready);
    end
    exp_d = wr ? merge_ref(model3[a], wd, be) : model3[a];
    if (wr) model3[a] = exp_d;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_be = be;
    resp_ready = 1'b0;
    tick();
    // fields are don't-care once accepted
    req_valid = 1'b0; req_write = $urandom; req_addr = $urandom; req_wdata = $urandom;
    req_be = $urandom;
    lat = 0; ok = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (resp_valid === 1'b1) begin lat = i; ok = 1'b1; break; end
    end
    rd = resp_rdata;
    checks++;
    if (!ok || lat != 3) begin
      failures++;
      $display("FAIL latency: got %0d edges need 3 (addr %h)", lat, a);
      resp_ready = 1'b0;
      do_reset(2);
      return;
    end
    checks++;
    if (resp_rdata !== exp_d) begin
      failures++;
      $display("FAIL rdata addr=%h wr=%b: got %h need %h", a, wr, resp_rdata, exp_d);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp_d || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold cycle %0d: valid=%b rdata=%h req_ready=%b need 1/%h/0",
                 h, resp_valid, resp_rdata, req_ready, exp_d);
      end
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: valid=%b rdata=%h busy=%b ready=%b need 0/0/0/1",
               resp_valid, resp_rdata, busy, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    // start a load of a nonzero word, then reset while it is in flight
    req_valid = 1'b1; req_write = 1'b0; req_addr = 7'd5; req_be = 4'h0;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    do_reset(2);
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: valid=%b rdata=%h busy=%b ready=%b need 0/0/0/1",
               resp_valid, resp_rdata, busy, req_ready);
    end
  endtask

  task automatic test_load();
    logic [31:0] rd;
    dut.mem[5] = 32'hDEADBEEF; model3[5] = 32'hDEADBEEF;
    access(1'b0, 7'd5, 32'h0, 4'hF, 4, rd);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL load_deadbeef: got %h need deadbeef", rd);
    end
  endtask

  task automatic test_store();
    logic [31:0] rd;
    dut.mem[9] = 32'h11223344; model3[9] = 32'h11223344;
    access(1'b1, 7'd9, 32'hAABBCCDD, 4'b0101, 0, rd);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL store_merge: got %h need 11bb33dd", rd);
    end
    access(1'b0, 7'd9, 32'h0, 4'h0, 1, rd);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL store_readback: got %h need 11bb33dd", rd);
    end
  endtask

  task automatic test_be_zero();
    logic [31:0] rd;
    logic [31:0] old_w;
    old_w = model3[7'd20];
    access(1'b1, 7'd20, ~old_w, 4'h0, 0, rd);
    checks++;
    if (rd !== old_w || dut.mem[20] !== old_w) begin
      failures++;
      $display("FAIL be_zero: rdata=%h mem=%h need %h", rd, dut.mem[20], old_w);
    end
  endtask

  task automatic test_reset_wait();
    bit seen;
    dut.mem[2] = 32'h0; model3[2] = 32'h0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 7'd2; req_wdata = 32'hCAFEF00D;
    req_be = 4'hF; resp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    seen = 1'b0;
    repeat (2) begin tick(); if (resp_valid) seen = 1'b1; end
    reset = 1'b0;
    repeat (6) begin tick(); if (resp_valid) seen = 1'b1; end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abort_no_resp: got resp_valid pulse need none");
    end
    checks++;
    if (dut.mem[2] !== 32'h0) begin
      failures++;
      $display("FAIL abort_no_write: mem[2]=%h need 00000000", dut.mem[2]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd, wd;
    wd = $urandom;
    dut.mem[0] = ~wd; model3[0] = ~wd;
    access(1'b1, 7'h7F, wd, 4'hF, 0, rd);
    access(1'b0, 7'h7F, 32'h0, 4'h0, 0, rd);
    checks++;
    if (rd !== wd) begin
      failures++;
      $display("FAIL wrap_7f: got %h need %h", rd, wd);
    end
    access(1'b0, 7'h00, 32'h0, 4'h0, 0, rd);
    checks++;
    if (rd !== ~wd) begin
      failures++;
      $display("FAIL wrap_00: got %h need %h", rd, ~wd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    for (int n = 0; n < 30; n++)
      access(1'($urandom), 7'($urandom), $urandom, 4'($urandom), $urandom_range(0, 2), rd);
  endtask

  task automatic test_back_to_back();
    int          cyc = 0, last_acc = -1, nresp = 0;
    bit          pending = 1'b0, will_accept;
    logic [6:0]  pend_addr = '0;
    req_valid1 = 1'b1; req_write1 = 1'b0; req_addr1 = 7'($urandom); resp_ready1 = 1'b1;
    for (int i = 0; i < 60 && nresp < 8; i++) begin
      will_accept = (req_ready1 === 1'b1);
      tick();
      cyc++;
      if (resp_valid1 === 1'b1) begin
        checks++;
        if (!pending || cyc - last_acc != 1 || resp_rdata1 !== model1[pend_addr]) begin
          failures++;
          $display("FAIL l1_resp: pend=%b delay=%0d need 1 rdata=%h need %h",
                   pending, cyc - last_acc, resp_rdata1, model1[pend_addr]);
        end
        pending = 1'b0;
        nresp++;
      end
      if (will_accept) begin
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 3) begin
            failures++;
            $display("FAIL l1_spacing: got %0d cycles need 3", cyc - last_acc);
          end
        end
        last_acc = cyc; pend_addr = req_addr1; pending = 1'b1;
        req_addr1 = 7'($urandom);
      end
    end
    req_valid1 = 1'b0;
    checks++;
    if (nresp != 8) begin
      failures++;
      $display("FAIL l1_count: got %0d responses need 8", nresp);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    resp_ready = 1'b0;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_be1 = '0;
    resp_ready1 = 1'b0;
    for (int i = 0; i < 128; i++) begin
      model3[i] = $urandom; dut.mem[i] = model3[i];
      model1[i] = $urandom; dut1.mem[i] = model1[i];
    end
    #1;
    test_reset();
    test_load();
    test_reset_mid();
    test_store();
    test_be_zero();
    test_reset_wait();
    test_wrap();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
